// File: rtl/dso100fb_sequencer.sv
// rtl/dso100fb_sequencer.sv - DSO100 framebuffer pipeline sequencer
// Orders fetch commands, FIFO flushes and timing enable around START/STOP requests.
module dso100fb_sequencer #(
  parameter int LEVEL_W   = 10,
  parameter int PREFILL   = 256,
  parameter int TIMEOUT_W = 20
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  output logic               STARTED,
  output logic               STOPPED,
  output logic [1:0]         STATE,
  input  logic [31:0]        FB_BASE,
  input  logic [22:0]        FB_LENGTH,
  output logic               FETCH_CMD_VALID,
  input  logic               FETCH_CMD_READY,
  output logic [31:0]        FETCH_CMD_BASE,
  output logic [22:0]        FETCH_CMD_LENGTH,
  input  logic               FETCH_BUSY,
  input  logic [LEVEL_W-1:0] FIFO_LEVEL,
  output logic               FIFO_FLUSH,
  output logic               TIMING_EN,
  input  logic               FRAME_END,
  output logic               OVERRUN,
  output logic               ERROR
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STARTING = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  localparam logic [LEVEL_W-1:0] PREFILL_LVL = LEVEL_W'(PREFILL);

  state_t               state, state_nx;
  logic                 cmd_valid, cmd_valid_nx;
  logic [31:0]          cmd_base, cmd_base_nx;
  logic [22:0]          cmd_length, cmd_length_nx;
  logic                 stop_pending, stop_pending_nx;
  logic [TIMEOUT_W-1:0] wdog, wdog_nx, wdog_inc;
  logic                 timing_en, timing_en_nx;
  logic                 started_q, started_nx;
  logic                 stopped_q, stopped_nx;
  logic                 flush_q, flush_nx;
  logic                 overrun_q, overrun_nx;
  logic                 error_q, error_nx;
  logic                 prefilled;

  assign prefilled = FIFO_LEVEL >= PREFILL_LVL;
  assign wdog_inc  = wdog + TIMEOUT_W'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      cmd_valid    <= 1'b0;
      cmd_base     <= '0;
      cmd_length   <= '0;
      stop_pending <= 1'b0;
      wdog         <= '0;
      timing_en    <= 1'b0;
      started_q    <= 1'b0;
      stopped_q    <= 1'b0;
      flush_q      <= 1'b0;
      overrun_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state        <= state_nx;
      cmd_valid    <= cmd_valid_nx;
      cmd_base     <= cmd_base_nx;
      cmd_length   <= cmd_length_nx;
      stop_pending <= stop_pending_nx;
      wdog         <= wdog_nx;
      timing_en    <= timing_en_nx;
      started_q    <= started_nx;
      stopped_q    <= stopped_nx;
      flush_q      <= flush_nx;
      overrun_q    <= overrun_nx;
      error_q      <= error_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    cmd_valid_nx    = cmd_valid;
    cmd_base_nx     = cmd_base;
    cmd_length_nx   = cmd_length;
    stop_pending_nx = stop_pending;
    wdog_nx         = wdog;
    timing_en_nx    = timing_en;
    started_nx      = 1'b0;
    stopped_nx      = 1'b0;
    flush_nx        = 1'b0;
    overrun_nx      = 1'b0;
    error_nx        = 1'b0;

    // A new command is only ever issued while VALID is low, so acceptance never collides with a latch.
    if (cmd_valid && FETCH_CMD_READY) cmd_valid_nx = 1'b0;

    case (state)
      ST_IDLE: begin
        if (START && !STOP && (FB_LENGTH != '0)) begin
          cmd_valid_nx  = 1'b1;
          cmd_base_nx   = FB_BASE;
          cmd_length_nx = FB_LENGTH;
          flush_nx      = 1'b1;
          wdog_nx       = '0;
          state_nx      = ST_STARTING;
        end
      end
      ST_STARTING: begin
        stop_pending_nx = stop_pending | STOP;
        wdog_nx         = wdog_inc;
        if (!cmd_valid && prefilled) begin
          if (stop_pending) begin
            state_nx = ST_STOPPING;
          end else begin
            state_nx     = ST_RUNNING;
            timing_en_nx = 1'b1;
            started_nx   = 1'b1;
          end
        end else if (&wdog_inc) begin
          error_nx = 1'b1;
          state_nx = ST_STOPPING;
        end
      end
      ST_RUNNING: begin
        // STOP arriving with FRAME_END only arms the next frame boundary.
        stop_pending_nx = stop_pending | STOP;
        if (FRAME_END) begin
          if (stop_pending) begin
            timing_en_nx = 1'b0;
            state_nx     = ST_STOPPING;
          end else if (!cmd_valid) begin
            cmd_valid_nx  = 1'b1;
            cmd_base_nx   = FB_BASE;
            cmd_length_nx = FB_LENGTH;
          end else begin
            overrun_nx = 1'b1;
          end
        end
      end
      ST_STOPPING: begin
        timing_en_nx = 1'b0;
        if (!cmd_valid && !FETCH_BUSY) begin
          flush_nx        = 1'b1;
          stopped_nx      = 1'b1;
          stop_pending_nx = 1'b0;
          state_nx        = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign STATE            = state;
  assign STARTED          = started_q;
  assign STOPPED          = stopped_q;
  assign FETCH_CMD_VALID  = cmd_valid;
  assign FETCH_CMD_BASE   = cmd_base;
  assign FETCH_CMD_LENGTH = cmd_length;
  assign FIFO_FLUSH       = flush_q;
  assign TIMING_EN        = timing_en;
  assign OVERRUN          = overrun_q;
  assign ERROR            = error_q;

endmodule

// File: tb/tb_dso100fb_sequencer.sv
// tb/tb_dso100fb_sequencer.sv - bench for dso100fb_sequencer
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_dso100fb_sequencer;
  localparam int LEVEL_W   = 10;
  localparam int PREFILL   = 4;
  localparam int TIMEOUT_W = 4;

  localparam int M_IDLE = 0, M_STARTING = 1, M_RUNNING = 2, M_STOPPING = 3;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               START = 1'b0;
  logic               STOP = 1'b0;
  logic [31:0]        FB_BASE = '0;
  logic [22:0]        FB_LENGTH = '0;
  logic               FETCH_CMD_READY = 1'b0;
  logic               FETCH_BUSY = 1'b0;
  logic [LEVEL_W-1:0] FIFO_LEVEL = '0;
  logic               FRAME_END = 1'b0;
  logic               STARTED, STOPPED, FETCH_CMD_VALID, FIFO_FLUSH, TIMING_EN, OVERRUN, ERROR;
  logic [1:0]         STATE;
  logic [31:0]        FETCH_CMD_BASE;
  logic [22:0]        FETCH_CMD_LENGTH;

  dso100fb_sequencer #(.LEVEL_W(LEVEL_W), .PREFILL(PREFILL), .TIMEOUT_W(TIMEOUT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
    .STARTED(STARTED), .STOPPED(STOPPED), .STATE(STATE),
    .FB_BASE(FB_BASE), .FB_LENGTH(FB_LENGTH),
    .FETCH_CMD_VALID(FETCH_CMD_VALID), .FETCH_CMD_READY(FETCH_CMD_READY),
    .FETCH_CMD_BASE(FETCH_CMD_BASE), .FETCH_CMD_LENGTH(FETCH_CMD_LENGTH),
    .FETCH_BUSY(FETCH_BUSY), .FIFO_LEVEL(FIFO_LEVEL), .FIFO_FLUSH(FIFO_FLUSH),
    .TIMING_EN(TIMING_EN), .FRAME_END(FRAME_END), .OVERRUN(OVERRUN), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int n_started = 0, n_stopped = 0, n_flush = 0, n_overrun = 0, n_error = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] base;
    logic [22:0] len;
  } cmd_t;

  int          m_mode = M_IDLE;
  cmd_t        m_q[$];
  logic [31:0] m_base = '0;
  logic [22:0] m_len = '0;
  bit          m_stop = 0;
  int          m_age = 0;
  bit          m_timing = 0;
  bit          m_started = 0, m_stopped = 0, m_flush = 0, m_overrun = 0, m_error = 0;

  task automatic m_reset();
    m_mode = M_IDLE; m_q.delete(); m_base = '0; m_len = '0; m_stop = 0; m_age = 0;
    m_timing = 0; m_started = 0; m_stopped = 0; m_flush = 0; m_overrun = 0; m_error = 0;
  endtask

  task automatic m_issue();
    cmd_t c;
    c.base = FB_BASE;
    c.len  = FB_LENGTH;
    m_q.push_back(c);
    m_base = FB_BASE;
    m_len  = FB_LENGTH;
  endtask

  task automatic m_step();
    bit had_cmd;
    bit take;
    had_cmd = (m_q.size() != 0);
    take    = had_cmd && FETCH_CMD_READY;
    m_started = 0; m_stopped = 0; m_flush = 0; m_overrun = 0; m_error = 0;
    case (m_mode)
      M_IDLE: if (START && !STOP && FB_LENGTH != 0) begin
        m_issue(); m_flush = 1; m_age = 0; m_mode = M_STARTING;
      end
      M_STARTING: begin
        if (!had_cmd && int'(FIFO_LEVEL) >= PREFILL) begin
          if (m_stop) m_mode = M_STOPPING;
          else begin m_mode = M_RUNNING; m_timing = 1; m_started = 1; end
        end else if (m_age + 1 == (1 << TIMEOUT_W) - 1) begin
          m_error = 1; m_mode = M_STOPPING;
        end
        m_age = m_age + 1;
        if (STOP) m_stop = 1;
      end
      M_RUNNING: begin
        if (FRAME_END) begin
          if (m_stop) begin m_timing = 0; m_mode = M_STOPPING; end
          else if (!had_cmd) m_issue();
          else m_overrun = 1;
        end
        if (STOP) m_stop = 1;
      end
      default: begin
        m_timing = 0;
        if (!had_cmd && !FETCH_BUSY) begin
          m_flush = 1; m_stopped = 1; m_stop = 0; m_mode = M_IDLE;
        end
      end
    endcase
    if (take) void'(m_q.pop_front());
  endtask

  initial begin : model_proc
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) m_reset();
      else m_step();
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge CLK);
      chk("state", 64'(STATE), 64'(m_mode));
      chk("cmd_valid", 64'(FETCH_CMD_VALID), 64'(m_q.size() != 0));
      chk("cmd_base", 64'(FETCH_CMD_BASE), 64'(m_base));
      chk("cmd_length", 64'(FETCH_CMD_LENGTH), 64'(m_len));
      chk("timing_en", 64'(TIMING_EN), 64'(m_timing));
      chk("started", 64'(STARTED), 64'(m_started));
      chk("stopped", 64'(STOPPED), 64'(m_stopped));
      chk("fifo_flush", 64'(FIFO_FLUSH), 64'(m_flush));
      chk("overrun", 64'(OVERRUN), 64'(m_overrun));
      chk("error", 64'(ERROR), 64'(m_error));
      if (STARTED) n_started++;
      if (STOPPED) n_stopped++;
      if (FIFO_FLUSH) n_flush++;
      if (OVERRUN) n_overrun++;
      if (ERROR) n_error++;
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string name);
    int n;
    n = 0;
    while (STATE !== s && n < max) begin
      step();
      n++;
    end
    chk(name, 64'(STATE), 64'(s));
  endtask

  int snap_started, snap_stopped, snap_flush, snap_overrun;
  int cnt, n;

  task automatic snap();
    snap_started = n_started; snap_stopped = n_stopped;
    snap_flush = n_flush; snap_overrun = n_overrun;
  endtask

  initial begin : main_proc
    repeat (2) step();
    RST_N = 1'b1;
    step();
    chk("reset_state", 64'(STATE), 64'd0);
    chk("reset_outputs", 64'({FETCH_CMD_VALID, TIMING_EN, STARTED, STOPPED, FIFO_FLUSH, OVERRUN, ERROR}), 64'd0);
    chk("reset_cmd_base", 64'(FETCH_CMD_BASE), 64'd0);

    // Start: command issued at once, accepted after 3 cycles, FIFO ramps to PREFILL.
    snap();
    FB_BASE = 32'h1000_0000; FB_LENGTH = 23'h1000; START = 1'b1;
    step(); START = 1'b0;
    chk("t1_state_starting", 64'(STATE), 64'd1);
    chk("t1_cmd_base", 64'(FETCH_CMD_BASE), 64'h1000_0000);
    chk("t1_cmd_length", 64'(FETCH_CMD_LENGTH), 64'h1000);
    repeat (3) step();
    FETCH_CMD_READY = 1'b1; FIFO_LEVEL = 1; step();
    FETCH_CMD_READY = 1'b0; FIFO_LEVEL = 2; step();
    FIFO_LEVEL = 3; step();
    FIFO_LEVEL = 4;
    wait_state(2'd2, 10, "t1_running");
    chk("t1_started_once", 64'(n_started - snap_started), 64'd1);
    chk("t1_flush_once", 64'(n_flush - snap_flush), 64'd1);
    chk("t1_timing_en", 64'(TIMING_EN), 64'd1);

    // Base update applies only at the next frame boundary.
    FB_BASE = 32'h2000_0000; step();
    chk("t2_base_held", 64'(FETCH_CMD_BASE), 64'h1000_0000);
    FRAME_END = 1'b1; step(); FRAME_END = 1'b0;
    chk("t2_new_valid", 64'(FETCH_CMD_VALID), 64'd1);
    chk("t2_new_base", 64'(FETCH_CMD_BASE), 64'h2000_0000);
    FETCH_CMD_READY = 1'b1; step(); FETCH_CMD_READY = 1'b0;
    chk("t2_accepted", 64'(FETCH_CMD_VALID), 64'd0);

    // Two frame ends with READY low: one overrun, command held.
    snap();
    FB_BASE = 32'h3000_0000; FRAME_END = 1'b1; step(); FRAME_END = 1'b0;
    repeat (5) step();
    FB_BASE = 32'h4000_0000; FRAME_END = 1'b1; step(); FRAME_END = 1'b0;
    step();
    chk("t3_overrun_once", 64'(n_overrun - snap_overrun), 64'd1);
    chk("t3_valid_held", 64'(FETCH_CMD_VALID), 64'd1);
    chk("t3_base_held", 64'(FETCH_CMD_BASE), 64'h3000_0000);
    FETCH_CMD_READY = 1'b1; step(); FETCH_CMD_READY = 1'b0;

    // Stop mid-frame, frame end 50 cycles later, busy drains 10 cycles after.
    FETCH_BUSY = 1'b1; STOP = 1'b1; step(); STOP = 1'b0;
    repeat (49) step();
    chk("t4_still_running", 64'(TIMING_EN), 64'd1);
    FRAME_END = 1'b1; step(); FRAME_END = 1'b0;
    chk("t4_timing_off", 64'(TIMING_EN), 64'd0);
    chk("t4_stopping", 64'(STATE), 64'd3);
    snap();
    repeat (9) step();
    chk("t4_no_early_stop", 64'(n_stopped - snap_stopped), 64'd0);
    FETCH_BUSY = 1'b0; step();
    chk("t4_idle", 64'(STATE), 64'd0);
    chk("t4_stopped_once", 64'(n_stopped - snap_stopped), 64'd1);
    chk("t4_flush_once", 64'(n_flush - snap_flush), 64'd1);

    // Ignored starts.
    snap();
    FB_LENGTH = '0; START = 1'b1; step(); START = 1'b0; step();
    FB_LENGTH = 23'h100; START = 1'b1; STOP = 1'b1; step(); START = 1'b0; STOP = 1'b0;
    STOP = 1'b1; step(); STOP = 1'b0;
    repeat (3) step();
    chk("t5_state_idle", 64'(STATE), 64'd0);
    chk("t5_no_cmd", 64'(FETCH_CMD_VALID), 64'd0);
    chk("t5_no_pulses", 64'((n_flush - snap_flush) + (n_started - snap_started) + (n_stopped - snap_stopped)), 64'd0);

    // Prefill timeout.
    snap();
    FIFO_LEVEL = 0; FETCH_CMD_READY = 1'b1; FB_LENGTH = 23'h200; START = 1'b1;
    step(); START = 1'b0;
    cnt = 0; n = 0;
    while (!ERROR && n < 40) begin
      if (STATE == 2'd1) cnt++;
      step();
      n++;
    end
    chk("t6_error_seen", 64'(ERROR), 64'd1);
    chk("t6_starting_cycles", 64'(cnt), 64'd15);
    wait_state(2'd0, 5, "t6_back_idle");
    chk("t6_stopped_once", 64'(n_stopped - snap_stopped), 64'd1);
    chk("t6_no_started", 64'(n_started - snap_started), 64'd0);

    // Asynchronous reset mid-RUNNING.
    FIFO_LEVEL = 4; START = 1'b1; step(); START = 1'b0;
    wait_state(2'd2, 20, "t7_running");
    FETCH_CMD_READY = 1'b0; FRAME_END = 1'b1; step(); FRAME_END = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("t7_reset_state", 64'(STATE), 64'd0);
    chk("t7_reset_flags", 64'({FETCH_CMD_VALID, TIMING_EN, STARTED, STOPPED, FIFO_FLUSH, OVERRUN, ERROR}), 64'd0);
    chk("t7_reset_cmd", 64'({FETCH_CMD_BASE, FETCH_CMD_LENGTH}), 64'd0);
    step(); step();
    RST_N = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      START           = ($urandom_range(0, 9) == 0);
      STOP            = ($urandom_range(0, 29) == 0);
      FRAME_END       = ($urandom_range(0, 19) == 0);
      FETCH_CMD_READY = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) FETCH_BUSY = ~FETCH_BUSY;
      FIFO_LEVEL      = LEVEL_W'($urandom_range(0, 6));
      FB_BASE         = $urandom;
      FB_LENGTH       = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
      step();
    end
    START = 1'b0; STOP = 1'b0; FRAME_END = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
